// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: default widths, packet layout, FSM states.
package noc_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 7;
    localparam int unsigned PKT_W  = DATA_W + ADDR_W;

    // Packet layout: payload in the high bits, destination in the low bits.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } pkt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    // Single place that fixes the {data, addr} packing order.
    function automatic pkt_t pack_pkt(input logic [DATA_W-1:0] data,
                                      input logic [ADDR_W-1:0] addr);
        pkt_t p;
        p.data = data;
        p.addr = addr;
        return p;
    endfunction

    // Index width for n sources; never narrower than one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/packet_merge_arbiter_if.sv
// Producer request bus and single merged output link of the packet arbiter.
interface packet_merge_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = noc_pkg::ADDR_W,
    parameter int unsigned DATA_W  = noc_pkg::DATA_W,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned PKT_W = DATA_W + ADDR_W;
    localparam int unsigned SRC_W = noc_pkg::src_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [PKT_W-1:0]          out_pkt;
    logic [SRC_W-1:0]          out_src;
    logic [CNT_W-1:0]          pkt_count;

    // Producers and downstream sink.
    modport master (
        output req_valid, req_addr, req_data, out_ready,
        input  req_ready, out_valid, out_pkt, out_src, pkt_count
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data, out_ready,
        output req_ready, out_valid, out_pkt, out_src, pkt_count
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping at NUM_REQ.
module rr_pick
    import noc_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned SRC_W   = src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [SRC_W-1:0]   idx_c,
    output logic               any_c
);

    // Scan ptr, ptr+1, ... with explicit wrap so NUM_REQ need not be a power of two.
    always_comb begin
        int unsigned      pos;
        logic [SRC_W-1:0] cand;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = SRC_W'(pos);
            if (!any_c && req[cand]) begin
                any_c = 1'b1;
                idx_c = cand;
            end
        end
        if (en && any_c) begin
            grant_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/packet_merge_arbiter.sv
// Round-robin merge of NUM_REQ addr/data producers onto one registered packet link.
module packet_merge_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = noc_pkg::ADDR_W,
    parameter int unsigned DATA_W  = noc_pkg::DATA_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    packet_merge_arbiter_if.slave bus
);

    localparam int unsigned PKT_W = DATA_W + ADDR_W;
    localparam int unsigned SRC_W = noc_pkg::src_w(NUM_REQ);

    noc_pkg::arb_state_e state_q, state_d;

    logic               load_en_c;
    logic               load_c;
    logic [NUM_REQ-1:0] grant_c;
    logic [SRC_W-1:0]   pick_idx_c;
    logic               pick_any_c;
    logic [SRC_W-1:0]   ptr_next_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic [PKT_W-1:0]   load_pkt_c;

    logic [SRC_W-1:0]   ptr_q;
    logic [PKT_W-1:0]   pkt_q;
    logic [SRC_W-1:0]   src_q;
    logic [CNT_W-1:0]   cnt_q;

    // Grants are suppressed while reset is asserted so producers never see a phantom accept.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .en      (load_en_c & rst_n),
        .grant_c (grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Packet register state: EMPTY always accepts, FULL accepts only when draining.
    always_comb begin
        state_d   = state_q;
        load_en_c = 1'b0;
        case (state_q)
            noc_pkg::EMPTY: begin
                load_en_c = 1'b1;
                if (pick_any_c) begin
                    state_d = noc_pkg::FULL;
                end
            end
            noc_pkg::FULL: begin
                if (bus.out_ready) begin
                    load_en_c = 1'b1;
                    if (!pick_any_c) begin
                        state_d = noc_pkg::EMPTY;
                    end
                end
            end
        endcase
    end

    assign load_c     = load_en_c & pick_any_c;
    assign sel_addr_c = bus.req_addr[pick_idx_c*ADDR_W +: ADDR_W];
    assign sel_data_c = bus.req_data[pick_idx_c*DATA_W +: DATA_W];
    assign ptr_next_c = (pick_idx_c == SRC_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + SRC_W'(1);

    // Reuse the shared packing helper when the widths match the package layout.
    if (ADDR_W == noc_pkg::ADDR_W && DATA_W == noc_pkg::DATA_W) begin : g_pkg_pack
        assign load_pkt_c = noc_pkg::pack_pkt(sel_data_c, sel_addr_c);
    end else begin : g_cat_pack
        assign load_pkt_c = {sel_data_c, sel_addr_c};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= noc_pkg::EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet register, source tag and round-robin pointer; all move only on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            src_q <= '0;
            ptr_q <= '0;
        end else if (load_c) begin
            pkt_q <= load_pkt_c;
            src_q <= pick_idx_c;
            ptr_q <= ptr_next_c;
        end
    end

    // Delivered-packet counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == noc_pkg::FULL && bus.out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.req_ready = grant_c;
    assign bus.out_valid = (state_q == noc_pkg::FULL);
    assign bus.out_pkt   = pkt_q;
    assign bus.out_src   = src_q;
    assign bus.pkt_count = cnt_q;

endmodule

// File: tb/tb_packet_merge_arbiter.sv
// Directed scenario bench for packet_merge_arbiter (4 producers, plus a 4-bit counter instance).
module tb_packet_merge_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    packet_merge_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(7), .CNT_W(16)) bus ();
    packet_merge_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(7), .CNT_W(4))  bus4 ();

    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_addr  = bus.req_addr;
    assign bus4.req_data  = bus.req_data;
    assign bus4.out_ready = bus.out_ready;

    packet_merge_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(7), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    packet_merge_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(7), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prod(input int i, input logic [3:0] a, input logic [6:0] d);
        bus.req_addr[i*4 +: 4] = a;
        bus.req_data[i*7 +: 7] = d;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        #2;
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_pkt !== 11'h000) begin bad++; $display("FAIL reset_pkt: got %h want 000", bus.out_pkt); end
        total++; if (bus.out_src !== 2'd0) begin bad++; $display("FAIL reset_src: got %0d want 0", bus.out_src); end
        total++; if (bus.pkt_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.pkt_count); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        bus.req_valid = 4'b0000;
        rst_n         = 1'b1;
    endtask

    task automatic test_reset_mid_full();
        bus.out_ready = 1'b0;
        set_prod(2, 4'h3, 7'h12);
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL midrst_grant: got %b want 0100", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL midrst_loaded: got %b want 1", bus.out_valid); end
        total++; if (bus.out_pkt !== 11'h123) begin bad++; $display("FAIL midrst_pkt: got %h want 123", bus.out_pkt); end
        total++; if (bus.out_src !== 2'd2) begin bad++; $display("FAIL midrst_src: got %0d want 2", bus.out_src); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_pkt !== 11'h000) begin bad++; $display("FAIL midrst_async_pkt: got %h want 000", bus.out_pkt); end
        total++; if (bus.pkt_count !== 16'd0) begin bad++; $display("FAIL midrst_async_count: got %0d want 0", bus.pkt_count); end
        step();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_ghost_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_pkt !== 11'h000) begin bad++; $display("FAIL midrst_no_ghost_pkt: got %h want 000", bus.out_pkt); end
        total++; if (bus.pkt_count !== 16'd0) begin bad++; $display("FAIL midrst_no_ghost_count: got %0d want 0", bus.pkt_count); end
    endtask

    task automatic test_round_robin();
        int g;
        for (int j = 0; j < 4; j++) set_prod(j, 4'(j), 7'(16 + j));
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            g = k % 4;
            total++; if (bus.req_ready !== 4'(1 << g)) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready, 4'(1 << g)); end
            step();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", k, bus.out_valid); end
            total++; if (bus.out_pkt !== {7'(16 + g), 4'(g)}) begin bad++; $display("FAIL rr_pkt[%0d]: got %h want %h", k, bus.out_pkt, {7'(16 + g), 4'(g)}); end
            total++; if (bus.out_src !== 2'(g)) begin bad++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, bus.out_src, g); end
        end
        bus.req_valid = 4'b0000;
        step();
        total++; if (bus.pkt_count !== 16'd6) begin bad++; $display("FAIL rr_count: got %0d want 6", bus.pkt_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rr_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_single();
        set_prod(1, 4'hA, 7'h55);
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", bus.req_ready); end
        step();
        bus.req_valid = 4'b0000;
        total++; if (bus.out_pkt !== 11'h55A) begin bad++; $display("FAIL single_pkt: got %h want 55a", bus.out_pkt); end
        total++; if (bus.out_src !== 2'd1) begin bad++; $display("FAIL single_src: got %0d want 1", bus.out_src); end
        total++; if (bus.pkt_count !== 16'd6) begin bad++; $display("FAIL single_count_pre: got %0d want 6", bus.pkt_count); end
        step();
        total++; if (bus.pkt_count !== 16'd7) begin bad++; $display("FAIL single_count_post: got %0d want 7", bus.pkt_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_prod(0, 4'h1, 7'h01);
        set_prod(3, 4'h2, 7'h33);
        bus.req_valid = 4'b1001;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_first_grant: got %b want 1000", bus.req_ready); end
        step();
        total++; if (bus.out_src !== 2'd3) begin bad++; $display("FAIL bp_first_src: got %0d want 3", bus.out_src); end
        for (int c = 0; c < 5; c++) begin
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold_ready[%0d]: got %b want 0000", c, bus.req_ready); end
            total++; if (bus.out_pkt !== 11'h332 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_pkt[%0d]: got %h/%b want 332/1", c, bus.out_pkt, bus.out_valid); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_reload_grant: got %b want 0001", bus.req_ready); end
        step();
        total++; if (bus.out_pkt !== 11'h011 || bus.out_src !== 2'd0) begin bad++; $display("FAIL bp_reload_pkt: got %h/%0d want 011/0", bus.out_pkt, bus.out_src); end
        total++; if (bus.pkt_count !== 16'd8) begin bad++; $display("FAIL bp_reload_count: got %0d want 8", bus.pkt_count); end
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant: got %b want 1000", bus.req_ready); end
        step();
        total++; if (bus.out_pkt !== 11'h332 || bus.out_src !== 2'd3) begin bad++; $display("FAIL bp_next_pkt: got %h/%0d want 332/3", bus.out_pkt, bus.out_src); end
        bus.req_valid = 4'b0000;
        step();
        total++; if (bus.pkt_count !== 16'd10) begin bad++; $display("FAIL bp_count: got %0d want 10", bus.pkt_count); end
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (bus4.pkt_count !== 4'd0) begin bad++; $display("FAIL wrap_reset: got %0d want 0", bus4.pkt_count); end
        set_prod(1, 4'h5, 7'h2A);
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b1;
        repeat (16) step();
        total++; if (bus4.pkt_count !== 4'd15) begin bad++; $display("FAIL wrap_15: got %0d want 15", bus4.pkt_count); end
        total++; if (bus.pkt_count !== 16'd15) begin bad++; $display("FAIL wrap_wide_15: got %0d want 15", bus.pkt_count); end
        step();
        total++; if (bus4.pkt_count !== 4'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", bus4.pkt_count); end
        total++; if (bus.pkt_count !== 16'd16) begin bad++; $display("FAIL wrap_wide_16: got %0d want 16", bus.pkt_count); end
        bus.req_valid = 4'b0000;
        step();
        total++; if (bus4.pkt_count !== 4'd1) begin bad++; $display("FAIL wrap_1: got %0d want 1", bus4.pkt_count); end
        total++; if (bus.pkt_count !== 16'd17) begin bad++; $display("FAIL wrap_wide_17: got %0d want 17", bus.pkt_count); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_sparse();
        set_prod(3, 4'h7, 7'h3C);
        bus.req_valid = 4'b1000;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL sparse_grant3: got %b want 1000", bus.req_ready); end
        step();
        total++; if (bus.out_pkt !== 11'h3C7 || bus.out_src !== 2'd3) begin bad++; $display("FAIL sparse_pkt3: got %h/%0d want 3c7/3", bus.out_pkt, bus.out_src); end
        set_prod(0, 4'h9, 7'h0F);
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL sparse_grant0: got %b want 0001", bus.req_ready); end
        step();
        total++; if (bus.out_pkt !== 11'h0F9 || bus.out_src !== 2'd0) begin bad++; $display("FAIL sparse_pkt0: got %h/%0d want 0f9/0", bus.out_pkt, bus.out_src); end
        bus.req_valid = 4'b0000;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL sparse_gap: got %b want 0", bus.out_valid); end
        bus.req_valid = 4'b0110;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL sparse_ptr1: got %b want 0010", bus.req_ready); end
        step();
        total++; if (bus.out_src !== 2'd1) begin bad++; $display("FAIL sparse_src1: got %0d want 1", bus.out_src); end
        bus.req_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_reset_mid_full();
        test_round_robin();
        test_single();
        test_backpressure();
        test_counter_wrap();
        test_sparse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
